// File: rtl/board_bank.sv
// Bank of Battleship boards with 2-bit cells: clear, bulk load, single-cell write and
// shot resolution. State advances on the falling clock edge; ship counts are combinational.
module board_bank #(
    parameter int NUM_BOARDS = 2,
    parameter int ROWS       = 5,
    parameter int COLS       = 5,
    localparam int BW = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int NC = ROWS * COLS,
    localparam int SW = $clog2(NC + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic [NUM_BOARDS-1:0]      load_en,
    input  logic [NUM_BOARDS*NC*2-1:0] load_data,
    input  logic                       wr_en,
    input  logic [BW-1:0]              wr_board,
    input  logic [RW-1:0]              wr_row,
    input  logic [CW-1:0]              wr_col,
    input  logic [1:0]                 wr_data,
    input  logic                       shot_en,
    input  logic [BW-1:0]              shot_board,
    input  logic [RW-1:0]              shot_row,
    input  logic [CW-1:0]              shot_col,
    output logic                       shot_valid,
    output logic [1:0]                 shot_result,
    output logic [NUM_BOARDS*NC*2-1:0] boards,
    output logic [NUM_BOARDS*SW-1:0]   ships_left,
    output logic [NUM_BOARDS-1:0]      defeated
);

    localparam logic [1:0] AGUA = 2'b00;
    localparam logic [1:0] SHIP = 2'b01;
    localparam logic [1:0] HIT  = 2'b10;
    localparam logic [1:0] MISS = 2'b11;

    logic [1:0]            cells_q [NUM_BOARDS][NC];
    logic [1:0]            cells_d [NUM_BOARDS][NC];
    logic [NUM_BOARDS-1:0] armed_q, armed_d;
    logic                  shot_valid_q, shot_valid_d;
    logic [1:0]            shot_result_q, shot_result_d;

    int         wr_b, wr_i, shot_b, shot_i;
    logic       wr_ok, shot_ok, wr_loaded, shot_loaded, same_cell;
    logic [1:0] shot_cell;

    // Target decode; wr_i/shot_i may alias a real cell when out of range, so they
    // are only ever used behind the *_ok qualifiers.
    always_comb begin
        wr_b      = int'(wr_board);
        wr_i      = int'(wr_row) * COLS + int'(wr_col);
        shot_b    = int'(shot_board);
        shot_i    = int'(shot_row) * COLS + int'(shot_col);
        wr_ok     = wr_en && (wr_b < NUM_BOARDS) && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
        shot_ok   = (shot_b < NUM_BOARDS) && (int'(shot_row) < ROWS) && (int'(shot_col) < COLS);
        same_cell = wr_ok && (shot_b == wr_b) && (shot_row == wr_row) && (shot_col == wr_col);
        wr_loaded   = 1'b0;
        shot_loaded = 1'b0;
        shot_cell   = AGUA;
        for (int b = 0; b < NUM_BOARDS; b++) begin
            if (load_en[b] && b == wr_b)   wr_loaded   = 1'b1;
            if (load_en[b] && b == shot_b) shot_loaded = 1'b1;
            for (int i = 0; i < NC; i++) begin
                if (b == shot_b && i == shot_i) shot_cell = cells_q[b][i];
            end
        end
    end

    always_comb begin
        cells_d       = cells_q;
        armed_d       = armed_q;
        shot_valid_d  = shot_en;
        shot_result_d = shot_result_q;
        if (clr) begin
            for (int b = 0; b < NUM_BOARDS; b++) begin
                for (int i = 0; i < NC; i++) cells_d[b][i] = AGUA;
            end
            armed_d = '0;
            if (shot_en) shot_result_d = 2'b11;
        end else begin
            for (int b = 0; b < NUM_BOARDS; b++) begin
                if (load_en[b]) begin
                    armed_d[b] = 1'b0;
                    for (int i = 0; i < NC; i++) begin
                        cells_d[b][i] = load_data[(b*NC+i)*2 +: 2];
                        if (load_data[(b*NC+i)*2 +: 2] == SHIP) armed_d[b] = 1'b1;
                    end
                end
            end
            if (wr_ok && !wr_loaded) begin
                for (int b = 0; b < NUM_BOARDS; b++) begin
                    for (int i = 0; i < NC; i++) begin
                        if (b == wr_b && i == wr_i) cells_d[b][i] = wr_data;
                    end
                    if (b == wr_b && wr_data == SHIP) armed_d[b] = 1'b1;
                end
            end
            // Shot outcome is judged on the pre-edge cell; a conflicting write wins the cell.
            if (shot_en) begin
                if (!shot_ok || shot_loaded || same_cell) begin
                    shot_result_d = 2'b11;
                end else begin
                    unique case (shot_cell)
                        SHIP:    shot_result_d = 2'b01;
                        AGUA:    shot_result_d = 2'b00;
                        default: shot_result_d = 2'b10;
                    endcase
                    for (int b = 0; b < NUM_BOARDS; b++) begin
                        for (int i = 0; i < NC; i++) begin
                            if (b == shot_b && i == shot_i) begin
                                if (shot_cell == SHIP)      cells_d[b][i] = HIT;
                                else if (shot_cell == AGUA) cells_d[b][i] = MISS;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < NUM_BOARDS; b++) begin
                for (int i = 0; i < NC; i++) cells_q[b][i] <= AGUA;
            end
            armed_q       <= '0;
            shot_valid_q  <= 1'b0;
            shot_result_q <= 2'b00;
        end else begin
            cells_q       <= cells_d;
            armed_q       <= armed_d;
            shot_valid_q  <= shot_valid_d;
            shot_result_q <= shot_result_d;
        end
    end

    assign shot_valid  = shot_valid_q;
    assign shot_result = shot_result_q;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_BOARDS; gi++) begin : g_board
            logic [SW-1:0] ship_cnt;
            for (gj = 0; gj < NC; gj++) begin : g_cell
                assign boards[(gi*NC+gj)*2 +: 2] = cells_q[gi][gj];
            end
            always_comb begin
                ship_cnt = '0;
                for (int i = 0; i < NC; i++) ship_cnt = ship_cnt + SW'(cells_q[gi][i] == SHIP);
            end
            assign ships_left[gi*SW +: SW] = ship_cnt;
            // An empty, never-armed board must not read as defeated.
            assign defeated[gi] = armed_q[gi] && (ship_cnt == '0);
        end
    endgenerate

endmodule

// File: tb/tb_board_bank.sv
// Bench for board_bank: directed scenarios then randomized traffic, each falling edge
// checked against a cell-array model that applies the game rules directly.
module tb_board_bank;

    localparam int NB = 2;
    localparam int R  = 5;
    localparam int C  = 5;
    localparam int NC = R * C;
    localparam int SW = 5;

    logic              clk, rst, clr;
    logic [NB-1:0]     load_en;
    logic [NB*NC*2-1:0] load_data;
    logic              wr_en;
    logic [0:0]        wr_board, shot_board;
    logic [2:0]        wr_row, wr_col, shot_row, shot_col;
    logic [1:0]        wr_data;
    logic              shot_en;
    logic              shot_valid;
    logic [1:0]        shot_result;
    logic [NB*NC*2-1:0] boards;
    logic [NB*SW-1:0]  ships_left;
    logic [NB-1:0]     defeated;

    board_bank #(.NUM_BOARDS(NB), .ROWS(R), .COLS(C)) dut (
        .clk(clk), .rst(rst), .clr(clr), .load_en(load_en), .load_data(load_data),
        .wr_en(wr_en), .wr_board(wr_board), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .shot_en(shot_en), .shot_board(shot_board), .shot_row(shot_row), .shot_col(shot_col),
        .shot_valid(shot_valid), .shot_result(shot_result), .boards(boards),
        .ships_left(ships_left), .defeated(defeated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [1:0] m_cell [NB][NC];
    logic [NB-1:0] m_armed;
    logic       m_valid;
    logic [1:0] m_result;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++) for (int i = 0; i < NC; i++) m_cell[b][i] = 2'b00;
        m_armed  = '0;
        m_valid  = 1'b0;
        m_result = 2'b00;
    endtask

    // Applies one falling edge worth of the game rules to the model.
    task automatic model_step();
        int wb, wi, sb, si;
        logic wok, sok;
        logic [1:0] res;
        res = m_result;
        if (clr) begin
            model_reset();
            if (shot_en) res = 2'b11;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (load_en[b]) begin
                    m_armed[b] = 1'b0;
                    for (int i = 0; i < NC; i++) begin
                        m_cell[b][i] = load_data[(b*NC+i)*2 +: 2];
                        if (m_cell[b][i] == 2'b01) m_armed[b] = 1'b1;
                    end
                end
            end
            wb  = int'(wr_board);
            wi  = int'(wr_row) * C + int'(wr_col);
            wok = wr_en && wb < NB && int'(wr_row) < R && int'(wr_col) < C;
            if (wok && !load_en[wb]) begin
                m_cell[wb][wi] = wr_data;
                if (wr_data == 2'b01) m_armed[wb] = 1'b1;
            end
            if (shot_en) begin
                sb  = int'(shot_board);
                si  = int'(shot_row) * C + int'(shot_col);
                sok = sb < NB && int'(shot_row) < R && int'(shot_col) < C;
                if (!sok || load_en[sb] || (wok && sb == wb && si == wi)) res = 2'b11;
                else if (m_cell[sb][si] == 2'b01) begin m_cell[sb][si] = 2'b10; res = 2'b01; end
                else if (m_cell[sb][si] == 2'b00) begin m_cell[sb][si] = 2'b11; res = 2'b00; end
                else res = 2'b10;
            end
        end
        m_valid  = shot_en;
        m_result = res;
    endtask

    task automatic compare_all(input string nm);
        logic [NB*NC*2-1:0] exp_boards;
        int cnt;
        for (int b = 0; b < NB; b++) for (int i = 0; i < NC; i++) exp_boards[(b*NC+i)*2 +: 2] = m_cell[b][i];
        check_eq({nm, "/valid"}, shot_valid, m_valid);
        check_eq({nm, "/result"}, shot_result, m_result);
        check_eq({nm, "/boards"}, boards, exp_boards);
        for (int b = 0; b < NB; b++) begin
            cnt = 0;
            for (int i = 0; i < NC; i++) if (m_cell[b][i] == 2'b01) cnt++;
            check_eq({nm, "/ships"}, ships_left[b*SW +: SW], cnt);
            check_eq({nm, "/defeated"}, defeated[b], m_armed[b] && cnt == 0);
        end
    endtask

    task automatic idle();
        clr = 0; load_en = '0; load_data = '0; wr_en = 0; wr_board = 0; wr_row = 0;
        wr_col = 0; wr_data = 0; shot_en = 0; shot_board = 0; shot_row = 0; shot_col = 0;
    endtask

    task automatic tick(input string nm);
        model_step();
        @(negedge clk);
        #1;
        compare_all(nm);
        cyc++;
        $display("cyc %0d %s clr=%b ld=%b wr=%b shot=%b -> valid=%b result=%b ships=%h def=%b",
                 cyc, nm, clr, load_en, wr_en, shot_en, shot_valid, shot_result, ships_left, defeated);
        idle();
    endtask

    task automatic shoot(input string nm, input int b, input int r, input int c);
        shot_en = 1; shot_board = 1'(b); shot_row = 3'(r); shot_col = 3'(c);
        tick(nm);
    endtask

    function automatic logic [NB*NC*2-1:0] rand_image();
        logic [NB*NC*2-1:0] v;
        for (int i = 0; i < NB * NC; i++) v[i*2 +: 2] = 2'($urandom_range(3));
        return v;
    endfunction

    initial begin
        idle();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        model_reset();
        compare_all("reset");
        @(posedge clk);
        rst = 1'b1;
        tick("idle");

        // Board 0 image with ships at (0,1), (1,2), (3,3); board-1 slice is garbage but not enabled.
        load_data = rand_image();
        for (int i = 0; i < NC; i++) load_data[i*2 +: 2] = 2'b00;
        load_data[1*2 +: 2]  = 2'b01;
        load_data[7*2 +: 2]  = 2'b01;
        load_data[18*2 +: 2] = 2'b01;
        load_en = 2'b01;
        tick("load0");
        check_eq("load_ships0", ships_left[0 +: SW], 3);
        check_eq("load_def0", defeated[0], 0);
        check_eq("load_board1", boards[NC*2 +: NC*2], 0);

        shoot("hit", 0, 1, 2);
        check_eq("hit_res", shot_result, 2'b01);
        check_eq("hit_cell", boards[7*2 +: 2], 2'b10);
        check_eq("hit_ships", ships_left[0 +: SW], 2);
        shoot("repeat", 0, 1, 2);
        check_eq("repeat_res", shot_result, 2'b10);
        shoot("miss", 0, 4, 4);
        check_eq("miss_res", shot_result, 2'b00);
        check_eq("miss_cell", boards[24*2 +: 2], 2'b11);
        shoot("row5", 0, 5, 0);
        check_eq("row5_res", shot_result, 2'b11);
        tick("gap");
        check_eq("pulse_drop", shot_valid, 0);
        shoot("sink1", 0, 0, 1);
        check_eq("sink1_def", defeated[0], 0);
        shoot("sink2", 0, 3, 3);
        check_eq("sink2_def", defeated[0], 1);

        wr_en = 1; wr_board = 0; wr_row = 0; wr_col = 0; wr_data = 2'b01;
        shot_en = 1; shot_board = 0; shot_row = 0; shot_col = 0;
        tick("wr_shot");
        check_eq("conflict_res", shot_result, 2'b11);
        check_eq("conflict_cell", boards[1:0], 2'b01);

        clr = 1; shot_en = 1; shot_board = 0; shot_row = 2; shot_col = 2;
        tick("clr_shot");
        check_eq("clr_res", shot_result, 2'b11);
        check_eq("clr_boards", boards, 0);

        load_en = 2'b11;
        load_data = rand_image();
        tick("rload");
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(99) < 2) clr = 1;
            for (int b = 0; b < NB; b++) if ($urandom_range(99) < 4) load_en[b] = 1'b1;
            if (load_en != '0) load_data = rand_image();
            wr_en    = ($urandom_range(99) < 35);
            wr_board = 1'($urandom_range(1));
            wr_row   = 3'($urandom_range(5));
            wr_col   = 3'($urandom_range(5));
            wr_data  = 2'($urandom_range(3));
            shot_en    = ($urandom_range(99) < 55);
            shot_board = 1'($urandom_range(1));
            shot_row   = 3'($urandom_range(5));
            shot_col   = 3'($urandom_range(5));
            if ($urandom_range(9) == 0) begin
                shot_board = wr_board; shot_row = wr_row; shot_col = wr_col;
            end
            tick("rand");
            if (n == 200) begin
                @(posedge clk);
                #1 rst = 1'b0;
                #1;
                model_reset();
                compare_all("midreset");
                @(posedge clk);
                rst = 1'b1;
                load_en = 2'b11;
                load_data = rand_image();
                tick("reload");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
